seq_divider: RTL and testbench

- Iterative unsigned restoring divider; the inverse of the combinational multiplier block.
- Recovers one factor from a product and the other factor, and also returns the remainder.
- Sits behind a valid/ready handshake on both sides, so it can be dropped into any streaming datapath and proven formally against the multiplier (quotient * divisor + remainder == dividend).
- One quotient bit per clock.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider_chk.sv | 47 ++++
 rtl/seq_divider.sv | 155 +++++++++++++++
 tb/tb_seq_divider.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a down-counter that starts at width-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Compare/subtract at WIDTH+1 bits; a clear borrow bit means the divisor fits.
  always_comb begin
    w_shift = {r, q_msb};
    w_diff  = w_shift - {1'b0, divisor};
    q_bit   = ~w_diff[WIDTH];
    if (q_bit) begin
      r_next = w_diff[WIDTH-1:0];
    end else begin
      r_next = w_shift[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_divider_chk.sv
// Protocol and arithmetic properties of seq_divider; bound in by the top.
module seq_divider_chk
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = cnt_width(WIDTH)
) (
  input logic             clk,
  input logic             rstn,
  input logic             in_ready,
  input logic             out_valid,
  input logic             out_ready,
  input logic             div_by_zero,
  input logic [WIDTH-1:0] quotient,
  input logic [WIDTH-1:0] remainder,
  input logic [WIDTH-1:0] divisor_l,
  input logic [WIDTH-1:0] dividend_l,
  input state_t           state,
  input logic [CW-1:0]    cnt
);

  logic [2*WIDTH-1:0] w_recon;

  // Rebuild the dividend from the result at double width.
  always_comb begin
    w_recon = {{WIDTH{1'b0}}, quotient} * {{WIDTH{1'b0}}, divisor_l}
            + {{WIDTH{1'b0}}, remainder};
  end

  a_inverse: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !div_by_zero) |->
      ((w_recon == {{WIDTH{1'b0}}, dividend_l}) && (remainder < divisor_l)));

  a_excl: assert property (@(posedge clk) disable iff (!rstn)
    !(in_ready && out_valid));

  a_stable: assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(quotient) && $stable(remainder) && $stable(div_by_zero)));

  a_cnt_last: assert property (@(posedge clk) disable iff (!rstn)
    ((state == BUSY) && (cnt == '0)) |=> (state == DONE));

  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    (state == BUSY) |-> (cnt <= CW'(WIDTH - 1)));

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic             w_accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_rem),
    .q_msb   (r_q[WIDTH-1]),
    .divisor (r_divisor),
    .r_next  (w_r_next),
    .q_bit   (w_q_bit)
  );

  // Next-state logic; accept and retire never overlap in one cycle.
  always_comb begin
    w_accept    = in_valid && r_in_ready;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (divisor == '0) ? DONE : BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Datapath: operand latch, restoring iterations and result registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_divisor   <= '0;
      r_dividend  <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_divisor  <= divisor;
            r_dividend <= dividend;
            r_q        <= dividend;
            r_rem      <= '0;
            r_cnt      <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_dbz <= 1'b0;
            end
          end
        end
        BUSY: begin
          r_rem <= w_r_next;
          r_q   <= {r_q[WIDTH-2:0], w_q_bit};
          if (r_cnt == '0) begin
            r_quotient  <= {r_q[WIDTH-2:0], w_q_bit};
            r_remainder <= w_r_next;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  seq_divider_chk #(.WIDTH(WIDTH), .CW(CW)) u_chk (
    .clk         (clk),
    .rstn        (rstn),
    .in_ready    (r_in_ready),
    .out_valid   (r_out_valid),
    .out_ready   (out_ready),
    .div_by_zero (r_dbz),
    .quotient    (r_quotient),
    .remainder   (r_remainder),
    .divisor_l   (r_divisor),
    .dividend_l  (r_dividend),
    .state       (r_state),
    .cnt         (r_cnt)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=32.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] n, input logic [W-1:0] d);
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    tick;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick;
      lat++;
    end
    chk("out_valid_reached", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  {63'd0, in_ready},    64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid},   64'd0);
    chk({tag, "_quotient"},  {32'd0, quotient},    64'd0);
    chk({tag, "_remainder"}, {32'd0, remainder},   64'd0);
    chk({tag, "_dbz"},       {63'd0, div_by_zero}, 64'd0);
  endtask

  initial begin
    int lat;
    int t_prev;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    logic [63:0]  recon;

    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = 32'd0;
    divisor   = 32'd0;
    tick;
    tick;
    chk_reset_state("reset");
    rstn = 1'b1;
    tick;

    launch(32'h0038fc70, 32'h00000072);
    wait_valid(lat);
    chk("inv_latency", 64'(lat), 64'd32);
    chk("inv_quotient", {32'd0, quotient}, 64'h7ff8);
    chk("inv_remainder", {32'd0, remainder}, 64'd0);
    chk("inv_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("inv_in_ready_done", {63'd0, in_ready}, 64'd0);
    tick;
    chk("inv_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("inv_in_ready_rise", {63'd0, in_ready}, 64'd1);

    launch(32'h00001234, 32'h00000000);
    wait_valid(lat);
    chk("dbz_latency", 64'(lat), 64'd0);
    chk("dbz_quotient", {32'd0, quotient}, 64'hffffffff);
    chk("dbz_remainder", {32'd0, remainder}, 64'h1234);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    tick;

    launch(32'hffffffff, 32'h80000000);
    wait_valid(lat);
    chk("max_latency", 64'(lat), 64'd32);
    chk("max_quotient", {32'd0, quotient}, 64'd1);
    chk("max_remainder", {32'd0, remainder}, 64'h7fffffff);
    chk("max_dbz", {63'd0, div_by_zero}, 64'd0);
    tick;

    out_ready = 1'b0;
    launch(32'd100, 32'd7);
    wait_valid(lat);
    chk("bp_quotient", {32'd0, quotient}, 64'd14);
    chk("bp_remainder", {32'd0, remainder}, 64'd2);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 32'd5;
      divisor  = 32'd1;
      tick;
      chk("bp_hold_quotient", {32'd0, quotient}, 64'd14);
      chk("bp_hold_remainder", {32'd0, remainder}, 64'd2);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_retire_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_retire_in_ready", {63'd0, in_ready}, 64'd1);

    launch(32'h0038fc70, 32'h00000072);
    repeat (10) tick;
    rstn = 1'b0;
    tick;
    chk_reset_state("midrst");
    rstn = 1'b1;
    launch(32'd9, 32'd3);
    wait_valid(lat);
    chk("post_rst_latency", 64'(lat), 64'd32);
    chk("post_rst_quotient", {32'd0, quotient}, 64'd3);
    chk("post_rst_remainder", {32'd0, remainder}, 64'd0);
    tick;

    // Back-to-back stream: in_valid held high, operands change after each accept.
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      rn = $urandom;
      rd = (k == 0) ? ($urandom | 32'd1) : 32'($urandom_range(32'hffff, 1));
      in_valid = 1'b1;
      dividend = rn;
      divisor  = rd;
      lat = 0;
      while (!in_ready && lat < 100) begin
        tick;
        lat++;
      end
      tick;
      wait_valid(lat);
      recon = 64'(quotient) * 64'(rd) + 64'(remainder);
      chk("b2b_recon", recon, 64'(rn));
      chk("b2b_rem_lt_div", {63'd0, (remainder < rd)}, 64'd1);
      chk("b2b_quotient", {32'd0, quotient}, 64'(rn / rd));
      if (k > 0) begin
        chk("b2b_period", 64'(cyc - t_prev), 64'd34);
      end
      t_prev = cyc;
    end
    in_valid = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
